sas_st_seq: RTL and testbench
=============================

Name: sas_st_seq

Overview:
Phase sequencer for the SAS-L2 client. It generates the 3-bit state code st that drives the downstream address-select decoder; that decoder selects Mn on st=000 and st=100 and An on every other code. Each word transfer walks st through a fixed phase sequence, paced by a ready input. A start/busy/done handshake frames bursts of one or more words.

Parameters:
LEN_W, 8, width of the burst-length input and of the word counter (maximum burst is 2^LEN_W-1 words)

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  reset
start  input  1  request a burst; sampled only in IDLE
len  input  LEN_W  number of words in the burst; latched when start is accepted
half  input  1  1 = 4-phase words (st 000..011); 0 = 8-phase words (st 000..111); latched with len
rdy  input  1  bus ready; advances st by one phase per cycle while high in RUN
abort  input  1  terminate the current burst
st  output  3  phase code to the address-select decoder
busy  output  1  high in RUN and FIN
done  output  1  one-cycle pulse at normal burst completion
aborted  output  1  one-cycle pulse when a burst is killed by abort
wcnt  output  LEN_W  words completed in the current or last burst

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high.
- All outputs are registered.
- Reset values: FSM=IDLE, st=000, busy=0, done=0, aborted=0, wcnt=0, latched len=0, latched half=0. Reset asserted mid-burst returns to these values immediately, with no done or aborted pulse.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - st=000, busy=0.
  - start=1 with len!=0: latch len and half, clear wcnt, go to RUN on the next edge with st=000 and busy=1.
  - start=1 with len=0: latch len, clear wcnt, go to FIN directly (zero-word burst). RUN is never entered.
- RUN, per cycle, in priority order:
  - abort=1: next edge goes to IDLE, st=000, aborted=1 for one cycle, done stays 0. wcnt holds its value. abort beats rdy in the same cycle.
  - rdy=0: st and wcnt hold.
  - rdy=1 and st is not the last phase: st increments by 1.
  - rdy=1 and st is the last phase (011 if half=1, else 111): the word is complete and wcnt increments by 1.
    - If the new wcnt equals latched len: go to FIN, st=000.
    - Otherwise: st wraps to 000 and RUN continues.
- Half mode: st[2] is never 1, so the sequence is 000,001,010,011,000,...
- FIN:
  - Lasts exactly one cycle: done=1, busy=1, st=000. Next edge goes to IDLE.
  - start, abort and rdy are ignored in FIN.
- start is ignored while busy=1, and latched len and half cannot change mid-burst.
- Latency: start sampled in IDLE, then first phase 000 presented in RUN on the next cycle.
- Minimum burst time (rdy held high, full mode): 1 + 8*len cycles from start to done.
- wcnt arithmetic is unsigned, LEN_W bits. Because wcnt terminates at len, it cannot wrap.
- In IDLE, st stays 000, so the downstream decoder presents Mn. This is the required idle bus address.

Decomposition:
- Shared package sas_pkg:
  - FSM state encoding constants: ST_IDLE, ST_RUN, ST_FIN.
  - Phase constants: PH_FIRST=3'b000, PH_LAST_HALF=3'b011, PH_LAST_FULL=3'b111.
  - Address-select meaning constants: ADR_AN=0, ADR_MN=1.
- One natural sub-module: sas_phase_cnt, the 3-bit phase counter with enable, synchronous clear and half-mode wrap. It reports "last phase" to the parent FSM.
- Word counter and FSM stay in sas_st_seq.

Test Plan:
- Reset mid-burst: assert rst while st=101 -> st=000, busy=0, wcnt=0 immediately; no done or aborted pulse afterwards.
- Full-mode single word: start=1, len=1, half=0, rdy always 1 -> st 000..111 over 8 cycles, then FIN with done=1 for one cycle; wcnt=1; done falls 9 cycles after start sampled.
- Half-mode 3-word burst with rdy toggling every other cycle -> st 000,001,010,011 repeated 3 times with each phase held through rdy=0 cycles; st[2] never 1; wcnt counts 1,2,3; single done pulse.
- Abort and rdy together at st=110, wcnt=2, len=5 -> next cycle IDLE, st=000, aborted=1 for one cycle, done=0, wcnt stays 2.
- len=0 start -> FIN the next cycle, done=1 for one cycle, st=000 throughout, wcnt=0.
- start pulsed during RUN with different len and half -> ignored; burst completes with the originally latched len and half.

Source files
------------

// File: rtl/sas_pkg.sv
// sas_pkg: shared definitions for the SAS-L2 phase sequencer.
//   state_t      - sequencer FSM states (IDLE, RUN, FIN)
//   PH_*         - phase code constants for st
//   ADR_*        - meaning of the downstream address-select decision
package sas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIN
    } state_t;

    localparam logic [2:0] PH_FIRST     = 3'b000;
    localparam logic [2:0] PH_LAST_HALF = 3'b011;
    localparam logic [2:0] PH_LAST_FULL = 3'b111;

    // Downstream decoder selects Mn on st=000/100, An otherwise.
    localparam logic ADR_AN = 1'b0;
    localparam logic ADR_MN = 1'b1;

endpackage

// File: rtl/sas_phase_cnt.sv
// sas_phase_cnt: 3-bit phase counter with enable, synchronous clear and
// half-mode wrap.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear to PH_FIRST (wins over en)
//   en       : advance one phase; wraps to PH_FIRST after the last phase
//   half     : 1 = last phase is 011, 0 = last phase is 111
//   ph       : current phase code (registered)
//   last     : ph is the last phase for the selected mode
module sas_phase_cnt
    import sas_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       half,
    output logic [2:0] ph,
    output logic       last
);

    always_comb begin
        last = (ph == (half ? PH_LAST_HALF : PH_LAST_FULL));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph <= PH_FIRST;
        end else if (clr) begin
            ph <= PH_FIRST;
        end else if (en) begin
            ph <= last ? PH_FIRST : ph + 3'd1;
        end
    end

endmodule

// File: rtl/sas_st_seq.sv
// sas_st_seq: phase sequencer for the SAS-L2 client. Walks st through a
// 4- or 8-phase sequence per word, paced by rdy, framing bursts with a
// start/busy/done handshake.
//   clk, rst : clock, asynchronous active-high reset
//   start    : burst request, sampled only in IDLE
//   len      : burst length in words, latched on accepted start
//   half     : 1 = 4-phase words, 0 = 8-phase words, latched with len
//   rdy      : advance one phase per cycle while high in RUN
//   abort    : kill the current burst (beats rdy)
//   st       : phase code to the address-select decoder
//   busy     : high in RUN and FIN
//   done     : one-cycle pulse on normal completion
//   aborted  : one-cycle pulse when a burst is aborted
//   wcnt     : words completed in the current or last burst
module sas_st_seq
    import sas_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             half,
    input  logic             rdy,
    input  logic             abort,
    output logic [2:0]       st,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [LEN_W-1:0] wcnt
);

    state_t           state, state_nx;
    logic [LEN_W-1:0] len_q, len_nx;
    logic             half_q, half_nx;
    logic [LEN_W-1:0] wcnt_nx;
    logic             aborted_nx;
    logic             ph_clr, ph_en, ph_last;

    // st is the counter register itself, so it stays a registered output.
    sas_phase_cnt u_phase (
        .clk  (clk),
        .rst  (rst),
        .clr  (ph_clr),
        .en   (ph_en),
        .half (half_q),
        .ph   (st),
        .last (ph_last)
    );

    always_comb begin
        state_nx   = state;
        len_nx     = len_q;
        half_nx    = half_q;
        wcnt_nx    = wcnt;
        aborted_nx = 1'b0;
        ph_clr     = 1'b1;
        ph_en      = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    len_nx  = len;
                    wcnt_nx = '0;
                    if (len != '0) begin
                        half_nx  = half;
                        state_nx = ST_RUN;
                    end else begin
                        state_nx = ST_FIN;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    aborted_nx = 1'b1;
                    state_nx   = ST_IDLE;
                end else begin
                    ph_clr = 1'b0;
                    ph_en  = rdy;
                    if (rdy && ph_last) begin
                        wcnt_nx = wcnt + 1'b1;
                        // Counter wraps to PH_FIRST on its own here.
                        if (wcnt_nx == len_q) state_nx = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // busy/done are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            len_q   <= '0;
            half_q  <= 1'b0;
            wcnt    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
        end else begin
            state   <= state_nx;
            len_q   <= len_nx;
            half_q  <= half_nx;
            wcnt    <= wcnt_nx;
            busy    <= (state_nx != ST_IDLE);
            done    <= (state_nx == ST_FIN);
            aborted <= aborted_nx;
        end
    end

endmodule

// File: tb/tb_sas_st_seq.sv
module tb_sas_st_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] len = '0;
    logic       half = 1'b0;
    logic       rdy = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] st;
    logic       busy, done, aborted;
    logic [7:0] wcnt;

    int tests = 0;
    int fails = 0;

    sas_st_seq #(.LEN_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .half(half),
        .rdy(rdy), .abort(abort), .st(st), .busy(busy), .done(done),
        .aborted(aborted), .wcnt(wcnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        tests++;
        if ({st, busy, done, aborted, wcnt} !== 14'd0) begin
            fails++;
            $display("FAIL reset: st=%b busy=%b done=%b aborted=%b wcnt=%0d required all 0",
                     st, busy, done, aborted, wcnt);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_full_word();
        start = 1'b1; len = 8'd1; half = 1'b0; rdy = 1'b1;
        step();
        start = 1'b0;
        tests++;
        if (st !== 3'd0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL full_first: st=%b busy=%b required st=000 busy=1", st, busy);
        end
        for (int i = 1; i < 8; i++) begin
            step();
            tests++;
            if (st !== 3'(i) || done !== 1'b0) begin
                fails++;
                $display("FAIL full_phase: st=%b done=%b required st=%b done=0", st, done, 3'(i));
            end
        end
        step();
        tests++;
        if (done !== 1'b1 || busy !== 1'b1 || st !== 3'd0 || wcnt !== 8'd1) begin
            fails++;
            $display("FAIL full_fin: done=%b busy=%b st=%b wcnt=%0d required 1 1 000 1",
                     done, busy, st, wcnt);
        end
        step();
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || wcnt !== 8'd1) begin
            fails++;
            $display("FAIL full_idle: done=%b busy=%b wcnt=%0d required 0 0 1", done, busy, wcnt);
        end
    endtask

    task automatic test_half_burst();
        int exp_st = 0, exp_w = 0, dones = 0, n = 0;
        bit fin = 0;
        start = 1'b1; len = 8'd3; half = 1'b1; rdy = 1'b0;
        step();
        start = 1'b0;
        while (!fin && n < 40) begin
            rdy = n[0];
            step();
            n++;
            if (rdy) begin
                if (exp_st == 3) begin
                    exp_st = 0;
                    exp_w++;
                    if (exp_w == 3) fin = 1;
                end else begin
                    exp_st++;
                end
            end
            if (done) dones++;
            tests++;
            if (st !== 3'(exp_st) || st[2] !== 1'b0 || wcnt !== 8'(exp_w) ||
                done !== fin) begin
                fails++;
                $display("FAIL half_seq: st=%b wcnt=%0d done=%b required st=%b wcnt=%0d done=%b",
                         st, wcnt, done, 3'(exp_st), exp_w, fin);
            end
        end
        rdy = 1'b0;
        step();
        if (done) dones++;
        tests++;
        if (!fin || dones != 1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL half_end: finished=%0d done_pulses=%0d busy=%b required 1 1 0",
                     fin, dones, busy);
        end
    endtask

    task automatic test_abort();
        start = 1'b1; len = 8'd5; half = 1'b0; rdy = 1'b1;
        step();
        start = 1'b0;
        repeat (22) step();
        tests++;
        if (st !== 3'b110 || wcnt !== 8'd2) begin
            fails++;
            $display("FAIL abort_setup: st=%b wcnt=%0d required 110 2", st, wcnt);
        end
        abort = 1'b1;
        step();
        abort = 1'b0; rdy = 1'b0;
        tests++;
        if (st !== 3'd0 || aborted !== 1'b1 || done !== 1'b0 || wcnt !== 8'd2 || busy !== 1'b0) begin
            fails++;
            $display("FAIL abort: st=%b aborted=%b done=%b wcnt=%0d busy=%b required 000 1 0 2 0",
                     st, aborted, done, wcnt, busy);
        end
        step();
        tests++;
        if (aborted !== 1'b0 || done !== 1'b0 || wcnt !== 8'd2) begin
            fails++;
            $display("FAIL abort_pulse: aborted=%b done=%b wcnt=%0d required 0 0 2", aborted, done, wcnt);
        end
    endtask

    task automatic test_zero_len();
        start = 1'b1; len = 8'd0; half = 1'b0; rdy = 1'b1;
        step();
        start = 1'b0;
        tests++;
        if (done !== 1'b1 || busy !== 1'b1 || st !== 3'd0 || wcnt !== 8'd0) begin
            fails++;
            $display("FAIL zero_fin: done=%b busy=%b st=%b wcnt=%0d required 1 1 000 0",
                     done, busy, st, wcnt);
        end
        step();
        rdy = 1'b0;
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || st !== 3'd0 || wcnt !== 8'd0) begin
            fails++;
            $display("FAIL zero_idle: done=%b busy=%b st=%b wcnt=%0d required 0 0 000 0",
                     done, busy, st, wcnt);
        end
    endtask

    task automatic test_start_ignored();
        start = 1'b1; len = 8'd2; half = 1'b1; rdy = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 2) begin start = 1'b1; len = 8'd7; half = 1'b0; end
            else start = 1'b0;
            step();
            tests++;
            if (st !== 3'(i % 4) || wcnt !== 8'(i / 4) || done !== (i == 8)) begin
                fails++;
                $display("FAIL start_ignored: step=%0d st=%b wcnt=%0d done=%b required st=%b wcnt=%0d done=%b",
                         i, st, wcnt, done, 3'(i % 4), i / 4, (i == 8));
            end
        end
        start = 1'b0; rdy = 1'b0;
        step();
        tests++;
        if (busy !== 1'b0 || wcnt !== 8'd2) begin
            fails++;
            $display("FAIL start_ignored_end: busy=%b wcnt=%0d required 0 2", busy, wcnt);
        end
    endtask

    task automatic test_reset_mid();
        start = 1'b1; len = 8'd3; half = 1'b0; rdy = 1'b1;
        step();
        start = 1'b0;
        repeat (13) step();
        tests++;
        if (st !== 3'b101 || wcnt !== 8'd1) begin
            fails++;
            $display("FAIL rstmid_setup: st=%b wcnt=%0d required 101 1", st, wcnt);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (st !== 3'd0 || busy !== 1'b0 || wcnt !== 8'd0 || done !== 1'b0 || aborted !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_async: st=%b busy=%b wcnt=%0d done=%b aborted=%b required 000 0 0 0 0",
                     st, busy, wcnt, done, aborted);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            tests++;
            if (done !== 1'b0 || aborted !== 1'b0 || busy !== 1'b0 || st !== 3'd0) begin
                fails++;
                $display("FAIL rstmid_after: done=%b aborted=%b busy=%b st=%b required 0 0 0 000",
                         done, aborted, busy, st);
            end
        end
        rdy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_half_burst();
        test_abort();
        test_zero_len();
        test_start_ignored();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
